// File: rtl/block_memory_responder.sv
// Block-granular main-memory responder: one 256-bit read or write at a time,
// fixed programmable latency, single-cycle mem_ready strobe.
module block_memory_responder #(
    parameter int unsigned LATENCY          = 4,
    parameter int unsigned ADDR_BLOCKS_LOG2 = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  mem_addr,
    input  logic [255:0] mem_wdata,
    input  logic         mem_read,
    input  logic         mem_write,
    output logic [255:0] mem_rdata,
    output logic         mem_ready,
    output logic         busy,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count,
    output logic         proto_err
);

    localparam int unsigned NBLK = 1 << ADDR_BLOCKS_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [7:0]                  cnt;
    logic [ADDR_BLOCKS_LOG2-1:0] idx_q;
    logic [255:0]                wdata_q;
    logic                        op_wr_q;
    logic                        access_fire;
    logic                        req;

    logic [255:0] mem_array [0:NBLK-1] = '{default: '0};

    logic unused_addr;
    assign unused_addr = ^{mem_addr[4:0], mem_addr[31:5+ADDR_BLOCKS_LOG2]};

    assign req         = mem_read | mem_write;
    assign access_fire = (state == S_BUSY) && (cnt == '0);
    assign mem_ready   = (state == S_RESP);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = S_BUSY;
            S_BUSY:  if (cnt == '0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture and latency countdown; write wins when both are requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
        end else if (state == S_IDLE) begin
            if (req) begin
                cnt     <= 8'(LATENCY - 1);
                idx_q   <= mem_addr[5+ADDR_BLOCKS_LOG2-1:5];
                wdata_q <= mem_wdata;
                op_wr_q <= mem_write;
            end
        end else if (state == S_BUSY && cnt != '0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Array storage has no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (access_fire && op_wr_q) begin
            mem_array[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata <= '0;
        end else if (access_fire && !op_wr_q) begin
            mem_rdata <= mem_array[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (state == S_RESP) begin
                if (op_wr_q) begin
                    if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                end else begin
                    if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                end
            end
            if (state == S_IDLE && mem_read && mem_write) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_block_memory_responder.sv
// Self-checking bench for block_memory_responder using a block-level
// reference model (associative array of blocks plus counters).
module tb_block_memory_responder;

    localparam int LAT  = 4;
    localparam int ABL2 = 10;

    logic         clk;
    logic         rst_n;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_rdata;
    logic         mem_ready;
    logic         busy;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;
    logic         proto_err;

    int nchecks = 0;
    int nerrs   = 0;

    logic [255:0] model_mem [int];
    logic [255:0] exp_rdata;
    int           exp_rd;
    int           exp_wr;
    logic         exp_perr;

    block_memory_responder #(
        .LATENCY(LAT),
        .ADDR_BLOCKS_LOG2(ABL2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy(busy),
        .rd_count(rd_count),
        .wr_count(wr_count),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int blk(input logic [31:0] a);
        return int'((a >> 5) % (1 << ABL2));
    endfunction

    function automatic logic [255:0] rand_block();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Drives a request (inputs left asserted) and returns in the RESP cycle.
    task automatic send(input logic w, input logic r, input logic [31:0] a,
                        input logic [255:0] d, input int exp_lat, input string tag);
        int lat;
        mem_write = w;
        mem_read  = r;
        mem_addr  = a;
        mem_wdata = d;
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_ready === 1'b1 || lat >= 300) break;
        end
        nchecks++;
        if (lat !== exp_lat || mem_ready !== 1'b1) begin
            nerrs++;
            $display("FAIL %s latency: got %0d (ready=%b) expected %0d", tag, lat, mem_ready, exp_lat);
        end
        nchecks++;
        if (busy !== 1'b1) begin
            nerrs++;
            $display("FAIL %s busy_in_resp: got %b expected 1", tag, busy);
        end
        if (w) begin
            model_mem[blk(a)] = d;
            if (exp_wr < 65535) exp_wr++;
            if (r) exp_perr = 1'b1;
        end else begin
            exp_rdata = model_mem.exists(blk(a)) ? model_mem[blk(a)] : '0;
            if (exp_rd < 65535) exp_rd++;
        end
        nchecks++;
        if (mem_rdata !== exp_rdata) begin
            nerrs++;
            $display("FAIL %s rdata_resp: got %h expected %h", tag, mem_rdata, exp_rdata);
        end
    endtask

    // Releases the request and checks the cycle after RESP.
    task automatic finish_op(input string tag);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        @(posedge clk);
        #1;
        nchecks++;
        if (mem_ready !== 1'b0 || busy !== 1'b0) begin
            nerrs++;
            $display("FAIL %s after_resp: ready=%b busy=%b expected 0 0", tag, mem_ready, busy);
        end
        nchecks++;
        if (mem_rdata !== exp_rdata) begin
            nerrs++;
            $display("FAIL %s rdata_hold: got %h expected %h", tag, mem_rdata, exp_rdata);
        end
        nchecks++;
        if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr) || proto_err !== exp_perr) begin
            nerrs++;
            $display("FAIL %s counters: rd=%0d wr=%0d perr=%b expected rd=%0d wr=%0d perr=%b",
                     tag, rd_count, wr_count, proto_err, exp_rd, exp_wr, exp_perr);
        end
    endtask

    task automatic apply_reset(input string tag);
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        exp_rd    = 0;
        exp_wr    = 0;
        exp_perr  = 1'b0;
        exp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        nchecks++;
        if (mem_rdata !== '0 || mem_ready !== 1'b0 || busy !== 1'b0 ||
            rd_count !== '0 || wr_count !== '0 || proto_err !== 1'b0) begin
            nerrs++;
            $display("FAIL %s reset_outputs: rdata=%h ready=%b busy=%b rd=%0d wr=%0d perr=%b expected all 0",
                     tag, mem_rdata, mem_ready, busy, rd_count, wr_count, proto_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset("reset");
        send(1'b0, 1'b1, 32'h0000_0040, '0, LAT + 1, "reset_read");
        finish_op("reset_read");
    endtask

    task automatic test_write_read();
        logic [255:0] pat;
        apply_reset("wr_rd");
        for (int k = 0; k < 8; k++) pat[32*k +: 32] = 32'hA5A5_0000 + k;
        send(1'b1, 1'b0, 32'h0000_1220, pat, LAT + 1, "wr_rd_write");
        finish_op("wr_rd_write");
        send(1'b0, 1'b1, 32'h0000_1234, '0, LAT + 1, "wr_rd_read");
        nchecks++;
        if (mem_rdata !== pat) begin
            nerrs++;
            $display("FAIL wr_rd_pattern: got %h expected %h", mem_rdata, pat);
        end
        finish_op("wr_rd_read");
    endtask

    task automatic test_back_to_back();
        logic [255:0] d;
        d = rand_block();
        model_mem[blk(32'h0000_0800)] = rand_block();
        send(1'b1, 1'b0, 32'h0000_0800, model_mem[blk(32'h0000_0800)], LAT + 1, "b2b_preload");
        finish_op("b2b_preload");
        send(1'b1, 1'b0, 32'h0000_0400, d, LAT + 1, "b2b_write");
        // Next request issued in the RESP cycle: sampled by IDLE the cycle after.
        send(1'b0, 1'b1, 32'h0000_0800, '0, LAT + 2, "b2b_read");
        finish_op("b2b_read");
        @(posedge clk);
        #1;
        nchecks++;
        if (mem_rdata !== exp_rdata || mem_ready !== 1'b0) begin
            nerrs++;
            $display("FAIL b2b_hold2: rdata=%h ready=%b expected %h 0", mem_rdata, mem_ready, exp_rdata);
        end
    endtask

    task automatic test_alias();
        logic [255:0] d;
        d = rand_block();
        send(1'b1, 1'b0, 32'h0000_8020, d, LAT + 1, "alias_write");
        finish_op("alias_write");
        send(1'b0, 1'b1, 32'h0000_0020, '0, LAT + 1, "alias_read");
        nchecks++;
        if (mem_rdata !== d) begin
            nerrs++;
            $display("FAIL alias_data: got %h expected %h", mem_rdata, d);
        end
        finish_op("alias_read");
    endtask

    task automatic test_proto_err();
        logic [255:0] d;
        apply_reset("perr");
        d = rand_block();
        send(1'b1, 1'b1, 32'h0000_0100, d, LAT + 1, "perr_both");
        finish_op("perr_both");
        nchecks++;
        if (proto_err !== 1'b1 || wr_count !== 16'd1 || rd_count !== 16'd0) begin
            nerrs++;
            $display("FAIL perr_flag: perr=%b wr=%0d rd=%0d expected 1 1 0", proto_err, wr_count, rd_count);
        end
        send(1'b0, 1'b1, 32'h0000_0100, '0, LAT + 1, "perr_readback");
        finish_op("perr_readback");
        nchecks++;
        if (proto_err !== 1'b1 || mem_rdata !== d) begin
            nerrs++;
            $display("FAIL perr_sticky: perr=%b rdata=%h expected 1 %h", proto_err, mem_rdata, d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [255:0] prior;
        prior = model_mem.exists(blk(32'h0000_0200)) ? model_mem[blk(32'h0000_0200)] : '0;
        mem_write = 1'b1;
        mem_addr  = 32'h0000_0200;
        mem_wdata = rand_block();
        repeat (2) @(posedge clk);
        #1;
        nchecks++;
        if (busy !== 1'b1) begin
            nerrs++;
            $display("FAIL midrst_busy: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        mem_write = 1'b0;
        #1;
        nchecks++;
        if (mem_rdata !== '0 || mem_ready !== 1'b0 || busy !== 1'b0 ||
            rd_count !== '0 || wr_count !== '0 || proto_err !== 1'b0) begin
            nerrs++;
            $display("FAIL midrst_async_clear: rdata=%h ready=%b busy=%b rd=%0d wr=%0d perr=%b expected all 0",
                     mem_rdata, mem_ready, busy, rd_count, wr_count, proto_err);
        end
        exp_rd = 0; exp_wr = 0; exp_perr = 1'b0; exp_rdata = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            nchecks++;
            if (mem_ready !== 1'b0) begin
                nerrs++;
                $display("FAIL midrst_no_ready: cycle %0d got %b expected 0", i, mem_ready);
            end
            if (i == 2) rst_n = 1'b1;
        end
        send(1'b0, 1'b1, 32'h0000_0200, '0, LAT + 1, "midrst_read");
        nchecks++;
        if (mem_rdata !== prior) begin
            nerrs++;
            $display("FAIL midrst_prior: got %h expected %h", mem_rdata, prior);
        end
        finish_op("midrst_read");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int op;
        for (int i = 0; i < 40; i++) begin
            a  = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 7)) << 5) | ($urandom & 32'h1F);
            op = $urandom_range(0, 9);
            if (op == 0)      send(1'b1, 1'b1, a, rand_block(), LAT + 1, "rand_both");
            else if (op < 5)  send(1'b1, 1'b0, a, rand_block(), LAT + 1, "rand_write");
            else              send(1'b0, 1'b1, a, '0, LAT + 1, "rand_read");
            finish_op("rand");
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_proto_err();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule

// File: doc/block_memory_responder.md
# block_memory_responder

Main-memory responder for the cache's block-refill/writeback interface. Accepts one 256-bit (32-byte) block read or write at a time, waits a programmable access latency, performs the access against an internal block array, and returns a single-cycle `mem_ready` pulse with read data held stable afterwards. It sits on the memory side of the direct-mapped cache and serves as both the simulation backing store and the template for a real DRAM controller front end.

## Interface
Parameters:
- `LATENCY`, 4: wait cycles between request acceptance and the response cycle (legal range 1..255).
- `ADDR_BLOCKS_LOG2`, 10: log2 of the number of 32-byte blocks stored (default 1024 blocks, 32 KB).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `mem_addr`  in  32  byte address. Bits [4:0] are ignored. Block index = `mem_addr[5+ADDR_BLOCKS_LOG2-1:5]`. Upper bits are ignored, so addresses alias modulo the array size.
- `mem_wdata`  in  256  write block. Word k occupies bits [32k+31:32k].
- `mem_read`  in  1  block read request, level-held by the requester.
- `mem_write`  in  1  block write request, level-held by the requester.
- `mem_rdata`  out  256  read block (registered).
- `mem_ready`  out  1  response strobe, high for exactly one cycle per accepted request.
- `busy`  out  1  high in BUSY and RESP.
- `rd_count`  out  16  completed reads; saturates at 0xFFFF.
- `wr_count`  out  16  completed writes; saturates at 0xFFFF.
- `proto_err`  out  1  sticky flag; set when `mem_read` and `mem_write` are seen together in IDLE.

## Operation
- States:
  - IDLE: sample the request. If `mem_write` or `mem_read` is high, latch the block index, `mem_wdata` and the op type, load `cnt = LATENCY-1`, and go to BUSY.
  - BUSY: decrement `cnt`. When `cnt == 0`, go to RESP and perform the access:
    - write: `array[idx] <= wdata_latched`.
    - read: `mem_rdata <= array[idx]`.
  - RESP: assert `mem_ready`, increment the matching counter, then go to IDLE.
- Read and write both high in IDLE: the write is serviced, the read is dropped, and `proto_err` is set. Only `rst_n` clears `proto_err`.
- Request inputs are ignored outside IDLE. A request deasserted during BUSY still completes and still pulses `mem_ready`.
- `mem_rdata` changes only on a read completion. It holds its value through the RESP cycle, the following cycle, and across later writes, until the next read completes. Requesters may sample it in RESP or in the cycle after RESP.
- Array contents are zero at time 0 and are not affected by `rst_n`.
- Reset (async, any state):
  - state = IDLE, `cnt` = 0.
  - `mem_ready` = 0, `busy` = 0, `mem_rdata` = 0.
  - `rd_count` = 0, `wr_count` = 0, `proto_err` = 0.
  - An in-flight write is discarded and the array is left unchanged.

## Timing
- Request first visible in IDLE in cycle C:
  - BUSY in cycles C+1 .. C+LATENCY.
  - RESP (`mem_ready` = 1) in cycle C+LATENCY+1.
  - IDLE again in cycle C+LATENCY+2.
- Request-to-ready latency is LATENCY+1 cycles. With LATENCY=1 that is 2 cycles.
- Back-to-back operation: the requester moves to its next request in the cycle after `mem_ready`, which is the cycle IDLE samples. A writeback followed by a refill therefore costs 2×(LATENCY+2)−1 cycles from the first request to the second `mem_ready`, with no lost cycle.
- `mem_ready` and `busy` are decoded from registered state and are glitch-free. `mem_ready` is never high for two consecutive cycles.
- `rd_count` and `wr_count` update at the edge ending RESP.

## Test plan
- Reset check: with `rst_n` = 0 then released:
  - all outputs are 0.
  - a read of address 0x0000_0040 with LATENCY=4 returns `mem_ready` in cycle 5 relative to the request and `mem_rdata` = 0.
- Write then read:
  - write 0x0000_1220 with `mem_wdata` word k = 0xA5A50000+k.
  - read 0x0000_1234; expect the same 256-bit pattern, `wr_count` = 1, `rd_count` = 1.
- Writeback+allocate sequence:
  - write block 0x0000_0400, and on the cycle after its `mem_ready` issue a read of 0x0000_0800.
  - Expect exactly two ready pulses, 6 cycles apart at LATENCY=4.
  - Expect the read data held stable for 2 cycles after its pulse.
- Aliasing: with ADDR_BLOCKS_LOG2=10, write 0x0000_8020 and read 0x0000_0020; expect the written data.
- Protocol error: assert `mem_read` and `mem_write` together at 0x100. Expect:
  - the write completes and `proto_err` = 1 and stays set.
  - `wr_count` = 1 and `rd_count` = 0.
- Reset mid-write: assert `rst_n` = 0 in the second BUSY cycle of a write to 0x200. Expect:
  - outputs cleared and no `mem_ready`.
  - a subsequent read of 0x200 returns the prior contents (0).
